// File: rtl/alu_32_seq.sv
// Multi-cycle 32-bit MIPS ALU: processes operands in SLICE_W-bit slices, one per
// cycle, with a carry register between slices and a start/finished handshake.
module alu_32_seq #(
    parameter int unsigned SLICE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  alu_control,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        err_illegal_alu_control,
    output logic        busy,
    output logic        finished
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned N_SLICES = DATA_W / SLICE_W;
    localparam int unsigned CNT_W    = $clog2(N_SLICES);
    localparam int unsigned IDX_W    = $clog2(DATA_W);
    localparam int unsigned SUM_W    = SLICE_W + 1;

    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N_SLICES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic [0:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              carry, carry_d;
    logic [DATA_W-1:0] a_q, a_q_d;
    logic [DATA_W-1:0] b_q, b_q_d;
    logic [3:0]        ctrl_q, ctrl_q_d;
    logic [DATA_W-1:0] result_d;
    logic              zero_d;
    logic              overflow_d;
    logic              err_d;
    logic              busy_d;
    logic              finished_d;

    logic [IDX_W-1:0]   base;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] slice_res;
    logic [SUM_W-1:0]   sum;
    logic               is_sub;
    logic               is_arith;
    logic               cin;
    logic               ovf_raw;
    logic               lt;
    logic               legal_code;

    // Request decode: only the six MIPS ALU control codes are accepted.
    always_comb begin
        legal_code = 1'b0;
        case (alu_control)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal_code = 1'b1;
            default: legal_code = 1'b0;
        endcase
    end

    // Slice datapath on the latched operands for the current slice index.
    always_comb begin
        base     = IDX_W'(32'(cnt) * SLICE_W);
        a_sl     = a_q[base +: SLICE_W];
        b_sl     = b_q[base +: SLICE_W];
        is_sub   = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
        is_arith = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB);
        b_eff    = is_sub ? ~b_sl : b_sl;
        cin      = (cnt == '0) ? is_sub : carry;
        sum      = SUM_W'(a_sl) + SUM_W'(b_eff) + SUM_W'(cin);
        // Only meaningful on the top slice, where the msbs are bit 31.
        ovf_raw  = (a_sl[SLICE_W-1] == b_eff[SLICE_W-1]) &&
                   (sum[SLICE_W-1] != a_sl[SLICE_W-1]);
        lt       = sum[SLICE_W-1] ^ ovf_raw;
        case (ctrl_q)
            OP_AND:  slice_res = a_sl & b_sl;
            OP_OR:   slice_res = a_sl | b_sl;
            OP_NOR:  slice_res = ~(a_sl | b_sl);
            default: slice_res = sum[SLICE_W-1:0];
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        carry_d    = carry;
        a_q_d      = a_q;
        b_q_d      = b_q;
        ctrl_q_d   = ctrl_q;
        result_d   = result;
        zero_d     = zero;
        overflow_d = overflow;
        err_d      = err_illegal_alu_control;
        busy_d     = busy;
        finished_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    a_q_d    = a;
                    b_q_d    = b;
                    ctrl_q_d = alu_control;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    if (legal_code) begin
                        state_d = S_EXEC;
                        cnt_d   = '0;
                        carry_d = 1'b0;
                        zero_d  = 1'b0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        zero_d     = 1'b1;
                        err_d      = 1'b1;
                        finished_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                result_d[base +: SLICE_W] = slice_res;
                carry_d = sum[SLICE_W];
                cnt_d   = cnt + 1'b1;
                if (cnt == LAST_SLICE) begin
                    if (ctrl_q == OP_SLT) begin
                        result_d = DATA_W'(lt);
                    end
                    overflow_d = is_arith && ovf_raw;
                    zero_d     = (result_d == '0);
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    busy_d     = 1'b0;
                    finished_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= S_IDLE;
            cnt                     <= '0;
            carry                   <= 1'b0;
            a_q                     <= '0;
            b_q                     <= '0;
            ctrl_q                  <= '0;
            result                  <= '0;
            zero                    <= 1'b0;
            overflow                <= 1'b0;
            err_illegal_alu_control <= 1'b0;
            busy                    <= 1'b0;
            finished                <= 1'b0;
        end else begin
            state                   <= state_d;
            cnt                     <= cnt_d;
            carry                   <= carry_d;
            a_q                     <= a_q_d;
            b_q                     <= b_q_d;
            ctrl_q                  <= ctrl_q_d;
            result                  <= result_d;
            zero                    <= zero_d;
            overflow                <= overflow_d;
            err_illegal_alu_control <= err_d;
            busy                    <= busy_d;
            finished                <= finished_d;
        end
    end

endmodule
